// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte interface among NUM_REQ requesters.
// Optional idle-timeout release is compiled in with `define UART_ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no owner; pick the next valid requester after the last owner
// ST_GRANT | owner's byte stream passes straight through to the transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 || IDLE_TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    logic [0:0]        state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  cand;
    logic              sel_found;
    logic [7:0]        burst_cnt;
    logic              xfer;
    logic              burst_hit;
    logic              release_pkt;
    logic              timeout_hit;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        sel       = ptr;
        cand      = ptr;
        sel_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        if (state == ST_GRANT) begin
            tx_valid         = req_valid[owner];
            tx_data          = req_data[owner*DATA_W +: DATA_W];
            req_ready[owner] = tx_ready;
        end
    end

    assign busy        = (state == ST_GRANT);
    assign xfer        = tx_valid && tx_ready;
    assign burst_hit   = (burst_cnt + 8'd1) == 8'(MAX_BURST);
    assign release_pkt = (xfer && (req_last[owner] || burst_hit)) || timeout_hit;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_hit = (state == ST_GRANT) && !req_valid[owner]
                         && ((idle_cnt + IDLE_W'(1)) == IDLE_W'(IDLE_TIMEOUT));

    // Held at zero outside GRANT, so every new grant starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != ST_GRANT || req_valid[owner]) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            owner     <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (sel_found) begin
                state     <= ST_GRANT;
                owner     <= sel;
                grant     <= NUM_REQ'(1) << sel;
                burst_cnt <= '0;
            end
        end else begin
            if (xfer) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
            if (release_pkt) begin
                state <= ST_IDLE;
                ptr   <= owner;
                grant <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// packet traffic scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int MAX_BURST    = 16;
    localparam int IDLE_TIMEOUT = 32;

    typedef struct {
        int               cyc;
        int               owner;
        logic [DATA_W-1:0] data;
    } xfer_t;

    typedef struct {
        logic [NUM_REQ-1:0] grant;
        logic               busy;
        logic               tx_valid;
        logic [DATA_W-1:0]  tx_data;
        logic [NUM_REQ-1:0] req_ready;
        logic               tx_ready;
    } snap_t;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;

    logic [DATA_W:0] q  [NUM_REQ][$];
    logic [DATA_W:0] mq [NUM_REQ][$];
    bit              hold [NUM_REQ];
    xfer_t           obs [$];
    xfer_t           exp_q [$];
    snap_t           trace [$];
    int              cyc;
    int              checks;
    int              errors;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive requesters from their queues at the negedge, sample, then advance.
    task automatic step(input bit rdy);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (q[i].size() > 0 && !hold[i]) begin
                req_valid[i]                   = 1'b1;
                req_data[i*DATA_W +: DATA_W]   = q[i][0][DATA_W-1:0];
                req_last[i]                    = q[i][0][DATA_W];
            end else begin
                req_valid[i]                   = 1'b0;
                req_data[i*DATA_W +: DATA_W]   = '0;
                req_last[i]                    = 1'b0;
            end
        end
        tx_ready = rdy;
        #1;
        trace.push_back('{grant, busy, tx_valid, tx_data, req_ready, tx_ready});
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                obs.push_back('{cyc, i, tx_data});
                void'(q[i].pop_front());
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            q[i].delete();
            mq[i].delete();
            hold[i] = 1'b0;
        end
        obs.delete();
        trace.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic push_byte(input int i, input logic [DATA_W-1:0] d, input bit last);
        q[i].push_back({last, d});
        mq[i].push_back({last, d});
    endtask

    // Round-robin over requesters with pending bytes; each grant carries bytes up to
    // the end of the packet or MAX_BURST, whichever comes first.
    task automatic build_expected();
        int p;
        int g;
        int cnt;
        bit any;
        bit done;
        logic [DATA_W:0] e;
        p = NUM_REQ - 1;
        exp_q.delete();
        while (1) begin
            any = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) if (mq[i].size() > 0) any = 1'b1;
            if (!any) break;
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++)
                if (g < 0 && mq[(p + k) % NUM_REQ].size() > 0) g = (p + k) % NUM_REQ;
            cnt  = 0;
            done = 1'b0;
            while (!done) begin
                e = mq[g].pop_front();
                exp_q.push_back('{0, g, e[DATA_W-1:0]});
                cnt++;
                done = e[DATA_W] || cnt == MAX_BURST || mq[g].size() == 0;
            end
            p = g;
        end
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NUM_REQ; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_data  = {NUM_REQ{8'h5C}};
        req_last  = '1;
        tx_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks += 5;
        if (grant !== '0)     begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        if (tx_data !== '0)   begin errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
        reset_dut();
    endtask

    task automatic test_single_packet();
        reset_dut();
        push_byte(0, 8'hA1, 1'b0);
        push_byte(0, 8'hA2, 1'b0);
        push_byte(0, 8'hA3, 1'b1);
        repeat (5) step(1'b1);
        checks += 3;
        if (trace[0].grant !== 4'b0000) begin errors++; $display("FAIL single_idle_grant: got %b expected 0000", trace[0].grant); end
        if (trace[1].grant !== 4'b0001 || trace[1].busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: got %b busy %b expected 0001 busy 1", trace[1].grant, trace[1].busy);
        end
        if (obs.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", obs.size()); end
        for (int k = 0; k < 3 && k < obs.size(); k++) begin
            checks++;
            if (obs[k].data !== 8'(8'hA1 + k) || obs[k].cyc != 1 + k) begin
                errors++;
                $display("FAIL single_byte%0d: got %h at cycle %0d expected %h at cycle %0d",
                         k, obs[k].data, obs[k].cyc, 8'(8'hA1 + k), 1 + k);
            end
        end
        checks++;
        if (trace[4].grant !== 4'b0000 || trace[4].busy !== 1'b0) begin
            errors++; $display("FAIL single_release: got %b busy %b expected 0000 busy 0", trace[4].grant, trace[4].busy);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int i = 0; i < NUM_REQ; i++) push_byte(i, 8'(8'h10 + i), 1'b1);
        repeat (9) step(1'b1);
        checks++;
        if (obs.size() != NUM_REQ) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", obs.size(), NUM_REQ); end
        for (int i = 0; i < NUM_REQ && i < obs.size(); i++) begin
            checks += 2;
            if (obs[i].data !== 8'(8'h10 + i) || obs[i].owner != i || obs[i].cyc != 1 + 2 * i) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h from req%0d at cycle %0d expected %h from req%0d at cycle %0d",
                         i, obs[i].data, obs[i].owner, obs[i].cyc, 8'(8'h10 + i), i, 1 + 2 * i);
            end
            if (trace[1 + 2 * i].grant !== 4'(1 << i) || trace[2 + 2 * i].grant !== 4'b0000) begin
                errors++;
                $display("FAIL b2b_grant%0d: got %b then %b expected %b then 0000",
                         i, trace[1 + 2 * i].grant, trace[2 + 2 * i].grant, 4'(1 << i));
            end
        end
    endtask

    task automatic test_burst_limit();
        int n;
        reset_dut();
        for (int k = 0; k < 20; k++) push_byte(0, 8'(8'h40 + k), k == 19);
        push_byte(1, 8'h99, 1'b1);
        build_expected();
        n = 0;
        while (!queues_empty() && n < 200) begin step(1'b1); n++; end
        checks += 3;
        if (!queues_empty()) begin errors++; $display("FAIL burst_timeout: got stalled after %0d cycles expected drain", n); end
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL burst_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        if (obs.size() > 16 && (obs[16].owner != 1 || obs[16].data !== 8'h99)) begin
            errors++; $display("FAIL burst_interleave: got req%0d %h expected req1 99", obs[16].owner, obs[16].data);
        end
        for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs[k].owner != exp_q[k].owner || obs[k].data !== exp_q[k].data) begin
                errors++;
                $display("FAIL burst_seq%0d: got req%0d %h expected req%0d %h",
                         k, obs[k].owner, obs[k].data, exp_q[k].owner, exp_q[k].data);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        reset_dut();
        for (int k = 0; k < 8; k++) push_byte(0, 8'(8'h60 + k), k == 7);
        repeat (4) step(1'b1);
        repeat (5) step(1'b0);
        n = 0;
        while (!queues_empty() && n < 30) begin step(1'b1); n++; end
        for (int k = 4; k < 9; k++) begin
            checks++;
            if (trace[k].req_ready !== '0 || trace[k].grant !== 4'b0001
                || trace[k].tx_valid !== 1'b1 || trace[k].tx_data !== 8'h63) begin
                errors++;
                $display("FAIL stall_cycle%0d: got ready %b grant %b valid %b data %h expected 0000 0001 1 63",
                         k, trace[k].req_ready, trace[k].grant, trace[k].tx_valid, trace[k].tx_data);
            end
        end
        checks++;
        if (obs.size() != 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", obs.size()); end
        for (int k = 0; k < obs.size() && k < 8; k++) begin
            checks++;
            if (obs[k].data !== 8'(8'h60 + k)) begin
                errors++; $display("FAIL stall_byte%0d: got %h expected %h", k, obs[k].data, 8'(8'h60 + k));
            end
        end
        checks++;
        if (obs.size() > 3 && obs[3].cyc != 9) begin
            errors++; $display("FAIL stall_resume: got cycle %0d expected 9", obs[3].cyc);
        end
    endtask

    task automatic test_reset_mid_packet();
        reset_dut();
        for (int k = 0; k < 6; k++) push_byte(2, 8'(8'hC0 + k), k == 5);
        repeat (3) step(1'b1);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        push_byte(0, 8'h5A, 1'b1);
        step(1'b1);
        step(1'b1);
        checks += 3;
        if (trace[2].grant !== 4'b0100) begin errors++; $display("FAIL rstmid_owner: got %b expected 0100", trace[2].grant); end
        if (trace[4].grant !== 4'b0000 || trace[4].busy !== 1'b0 || trace[4].tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got grant %b busy %b valid %b expected 0000 0 0",
                     trace[4].grant, trace[4].busy, trace[4].tx_valid);
        end
        if (trace[5].grant !== 4'b0001) begin errors++; $display("FAIL rstmid_regrant: got %b expected 0001", trace[5].grant); end
    endtask

    task automatic test_idle_timeout();
        reset_dut();
        for (int k = 0; k < 3; k++) push_byte(0, 8'(8'hD0 + k), k == 2);
        push_byte(1, 8'hE7, 1'b1);
        step(1'b1);
        step(1'b1);
        hold[0] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        repeat (IDLE_TIMEOUT + 2) step(1'b1);
        for (int k = 1; k <= IDLE_TIMEOUT + 2; k++) begin
            checks++;
            if (trace[1 + k].grant !== (k <= IDLE_TIMEOUT ? 4'b0001 : (k == IDLE_TIMEOUT + 1 ? 4'b0000 : 4'b0010))) begin
                errors++; $display("FAIL timeout_grant_c%0d: got %b", k, trace[1 + k].grant);
            end
        end
        checks++;
        if (obs.size() != 2 || obs[obs.size() - 1].owner != 1 || obs[obs.size() - 1].data !== 8'hE7) begin
            errors++; $display("FAIL timeout_next: got %0d transfers expected req1 E7 as second", obs.size());
        end
`else
        repeat (100) step(1'b1);
        for (int k = 1; k <= 100; k++) begin
            checks++;
            if (trace[1 + k].grant !== 4'b0001) begin
                errors++; $display("FAIL hold_grant_c%0d: got %b expected 0001", k, trace[1 + k].grant);
            end
        end
        checks++;
        if (obs.size() != 1) begin errors++; $display("FAIL hold_count: got %0d expected 1", obs.size()); end
`endif
    endtask

    task automatic test_random();
        int n;
        int npk;
        int len;
        for (int it = 0; it < 20; it++) begin
            reset_dut();
            for (int i = 0; i < NUM_REQ; i++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 24);
                    for (int k = 0; k < len; k++) push_byte(i, 8'($urandom), k == len - 1);
                end
            end
            build_expected();
            n = 0;
            while (!queues_empty() && n < 3000) begin step($urandom_range(0, 3) != 0); n++; end
            checks += 2;
            if (!queues_empty()) begin errors++; $display("FAIL rand%0d_drain: got stall after %0d cycles", it, n); end
            if (obs.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, obs.size(), exp_q.size());
            end
            for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
                checks++;
                if (obs[k].owner != exp_q[k].owner || obs[k].data !== exp_q[k].data) begin
                    errors++;
                    $display("FAIL rand%0d_seq%0d: got req%0d %h expected req%0d %h",
                             it, k, obs[k].owner, obs[k].data, exp_q[k].owner, exp_q[k].data);
                end
            end
            for (int k = 0; k < trace.size(); k++) begin
                checks++;
                if (trace[k].req_ready !== (trace[k].busy ? (trace[k].grant & {NUM_REQ{trace[k].tx_ready}}) : '0)
                    || trace[k].busy !== (trace[k].grant != '0) || !$onehot0(trace[k].grant)
                    || (k > 0 && trace[k - 1].grant != '0 && trace[k].grant != '0
                        && trace[k - 1].grant != trace[k].grant)) begin
                    errors++;
                    $display("FAIL rand%0d_proto_c%0d: got grant %b busy %b ready %b", it, k,
                             trace[k].grant, trace[k].busy, trace[k].req_ready);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_burst_limit();
        test_backpressure();
        test_reset_mid_packet();
        test_idle_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
